// File: rtl/adder_share_arbiter_pkg.sv
// Shared definitions for the adder-sharing arbiter: FSM encoding and the
// fixed operand width of the shared adder.
package adder_share_arbiter_pkg;

  localparam int ADD_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Pointer width for a requester index; never collapses to zero bits.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_share_arbiter_adder.sv
// Shared 16-bit adder with carry-in and carry-out.
module my16bitadder
  import adder_share_arbiter_pkg::*;
(
  input  logic [ADD_WIDTH-1:0] a,
  input  logic [ADD_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [ADD_WIDTH-1:0] sum,
  output logic                 cout
);

  logic [ADD_WIDTH:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{ADD_WIDTH{1'b0}}, cin};
  assign sum  = full[ADD_WIDTH-1:0];
  assign cout = full[ADD_WIDTH];

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter letting N_REQ requesters time-share one 16-bit adder.
//   state  | meaning
//   IDLE   | waiting for a request; grant issued combinationally
//   ADD    | latched operands drive the adder for one cycle
//   RESP   | result held on rsp_* until the owner accepts it
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  // Tied to the shared adder width; leave at default.
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_cin,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_cout,
  output logic                   busy
);

  localparam int PTR_W = ptr_width(N_REQ);

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   rr_next;
  logic               win_found;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               op_cin;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [N_REQ-1:0]   owner_oh;
  logic               owner_ready;

  // Single priority search starting at rr_ptr and wrapping modulo N_REQ.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
  end

  assign rr_next = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && win_found) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  assign owner_ready = |(rsp_ready & owner_oh);

  my16bitadder u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      rsp_valid <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            op_a   <= req_a[win_idx*WIDTH +: WIDTH];
            op_b   <= req_b[win_idx*WIDTH +: WIDTH];
            op_cin <= req_cin[win_idx];
            owner  <= win_idx;
            rr_ptr <= rr_next;
            busy   <= 1'b1;
            state  <= S_ADD;
          end
        end
        S_ADD: begin
          rsp_sum   <= add_sum;
          rsp_cout  <= add_cout;
          rsp_valid <= owner_oh;
          state     <= S_RESP;
        end
        S_RESP: begin
          // Only the owner's acceptance retires the result.
          if (owner_ready) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid <= '0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench: transaction-level reference model compared every cycle,
// plus directed scenarios pinned to hand-computed values.
module tb_adder_share_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           Clk;
  logic           Reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic           busy;

  adder_share_arbiter #(.N_REQ(N)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: one outstanding transaction, described by its age.
  bit          model_live = 0;
  int          m_rr = 0;
  bit          m_busy = 0;
  bit          m_rsp = 0;
  int          m_owner = 0;
  int          m_age = 0;
  logic [16:0] m_full = '0;
  logic [15:0] m_sum = '0;
  logic        m_cout = 1'b0;

  function automatic int pick(input int rr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (rr + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      model_live = 1;
      m_rr = 0; m_busy = 0; m_rsp = 0; m_sum = '0; m_cout = 1'b0;
    end else if (model_live) begin
      if (!m_busy) begin
        int w;
        w = pick(m_rr, req_valid);
        if (w >= 0) begin
          m_busy  = 1;
          m_owner = w;
          m_age   = 0;
          m_full  = 17'(req_a[w*W +: W]) + 17'(req_b[w*W +: W]) + 17'(req_cin[w]);
          m_rr    = (w + 1) % N;
        end
      end else if (m_age == 0) begin
        m_age  = 1;
        m_rsp  = 1;
        m_sum  = m_full[15:0];
        m_cout = m_full[16];
      end else if (rsp_ready[m_owner]) begin
        m_rsp  = 0;
        m_busy = 0;
      end
    end
  end

  int grant_log[$];
  int rsp_log[$];

  always @(negedge Clk) begin
    if (model_live) begin
      logic [N-1:0] exp_ready, exp_rv;
      int w;
      exp_ready = '0;
      exp_rv    = '0;
      if (!m_busy) begin
        w = pick(m_rr, req_valid);
        if (w >= 0) exp_ready[w] = 1'b1;
      end
      if (m_rsp) exp_rv[m_owner] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      check("busy", 32'(busy), 32'(m_busy));
      check("rsp_sum", 32'(rsp_sum), 32'(m_sum));
      check("rsp_cout", 32'(rsp_cout), 32'(m_cout));
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) grant_log.push_back(i);
      if (rsp_valid[i] && rsp_ready[i]) rsp_log.push_back(int'(rsp_sum));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = c;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    Reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = '1;
    do_reset();

    // Reset state.
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_sum", 32'(rsp_sum), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);

    // Single op: 10 + 10.
    set_op(0, 16'd10, 16'd10, 1'b0);
    req_valid = 4'b0001;
    #1 check("single_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    check("single_add_ready", 32'(req_ready), 32'd0);
    check("single_add_busy", 32'(busy), 32'd1);
    check("single_add_rv", 32'(rsp_valid), 32'd0);
    tick();
    check("single_rv", 32'(rsp_valid), 32'b0001);
    check("single_sum", 32'(rsp_sum), 32'd20);
    check("single_cout", 32'(rsp_cout), 32'd0);
    tick();
    check("single_done_busy", 32'(busy), 32'd0);
    check("single_hold_sum", 32'(rsp_sum), 32'd20);

    // Overflow on requester 1.
    set_op(1, 16'hFFFF, 16'h0001, 1'b1);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    check("ovf_rv", 32'(rsp_valid), 32'b0010);
    check("ovf_sum", 32'(rsp_sum), 32'h0001);
    check("ovf_cout", 32'(rsp_cout), 32'd1);
    tick();

    // Fairness with all requesters active.
    do_reset();
    grant_log.delete();
    rsp_log.delete();
    for (int i = 0; i < N; i++) set_op(i, 16'(i), 16'd100, 1'b0);
    req_valid = '1;
    repeat (15) tick();
    req_valid = '0;
    repeat (4) tick();
    check("fair_count", 32'(grant_log.size() >= 5), 32'd1);
    if (grant_log.size() >= 5 && rsp_log.size() >= 5) begin
      int exp_g[5] = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
        check("fair_grant", 32'(grant_log[k]), 32'(exp_g[k]));
        check("fair_sum", 32'(rsp_log[k]), 32'(100 + exp_g[k]));
      end
    end

    // Backpressure on requester 2 while requester 0 is ready.
    do_reset();
    set_op(2, 16'd7, 16'd8, 1'b0);
    set_op(0, 16'd1, 16'd2, 1'b0);
    rsp_ready = 4'b0001;
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0001;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_rv", 32'(rsp_valid), 32'b0100);
      check("bp_sum", 32'(rsp_sum), 32'd15);
      check("bp_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 4'b0101;
    tick();
    check("bp_release", 32'(rsp_valid), 32'd0);
    check("bp_next_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    repeat (4) tick();

    // Reset while in ADD discards the transaction.
    rsp_ready = '1;
    set_op(2, 16'd5, 16'd5, 1'b0);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst_add_rv", 32'(rsp_valid), 32'd0);
    check("rst_add_busy", 32'(busy), 32'd0);
    req_valid = '1;
    #1 check("rst_add_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    repeat (4) tick();

    // Randomized traffic, model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      Reset     = ($urandom_range(0, 199) == 0);
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        set_op(i, ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
               16'($urandom), 1'($urandom));
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    Reset = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters sharing the 16-bit adder (2..8).
REQ-002 Parameter: WIDTH, 16, operand width; fixed to the shared adder width, SHALL NOT be overridden.
REQ-003 Clk  input  1  clock; all state changes on rising edge.
REQ-004 Reset  input  1  reset Reset, synchronous, active-high; clock Clk.
REQ-005 req_valid  input  N_REQ  per-requester operation request.
REQ-006 req_ready  output  N_REQ  one-hot grant/accept; transfer when req_valid[i] & req_ready[i].
REQ-007 req_a  input  N_REQ*16  packed operand A, slice i = [16i+15:16i].
REQ-008 req_b  input  N_REQ*16  packed operand B, same packing.
REQ-009 req_cin  input  N_REQ  per-requester carry-in.
REQ-010 rsp_valid  output  N_REQ  one-hot result-valid to the owning requester.
REQ-011 rsp_ready  input  N_REQ  per-requester result acceptance.
REQ-012 rsp_sum  output  16  shared result bus.
REQ-013 rsp_cout  output  1  carry-out of the result.
REQ-014 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-015 FSM SHALL have three states: IDLE, ADD, RESP.
REQ-016 IDLE: if any req_valid, assert req_ready for exactly one winner (combinational from req_valid and rr pointer); on that edge latch the winner's A, B, cin and index, then go to ADD.
REQ-017 IDLE with no req_valid: req_ready all zero, remain IDLE.
REQ-018 Arbitration SHALL be round-robin: search starts at rr_ptr, wraps modulo N_REQ; after a grant rr_ptr = winner+1 mod N_REQ.
REQ-019 ADD: latched operands drive the adder for one full cycle; on the exiting edge capture sum and cout into output registers, go to RESP.
REQ-020 RESP: rsp_valid[owner]=1 with rsp_sum/rsp_cout stable; when rsp_ready[owner]=1, clear rsp_valid on that edge and return to IDLE.
REQ-021 Latency: accept edge N -> rsp_valid high from edge N+2; minimum issue interval 3 cycles with rsp_ready held high.
REQ-022 req_ready SHALL be zero in ADD and RESP; no new accept until back in IDLE.
REQ-023 rsp_ready of non-owners SHALL be ignored; rsp_valid never has more than one bit set.
REQ-024 Arithmetic: rsp_sum = (A+B+cin) mod 2^16; rsp_cout = bit 16 of the full sum.
REQ-025 Requester dropping req_valid before acceptance: no grant, no state change for it; rr_ptr unaffected.
REQ-026 Simultaneous req_valid on all requesters: exactly one accepted per transaction, served in rotating order, no starvation (each served within N_REQ transactions).
REQ-027 rsp_sum/rsp_cout SHALL hold last result when rsp_valid is low.

Reset
REQ-028 Reset SHALL force state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, busy=0.
REQ-029 Reset mid-operation (ADD or RESP) SHALL discard the transaction; no rsp_valid is produced for it.
REQ-030 Reset has priority over every other condition on the same edge.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding (IDLE=0, ADD=1, RESP=2) and the 16-bit width constant.
REQ-032 The adder SHALL be the existing my16bitadder instantiated once as the sole sub-module; no other arithmetic in this block.
REQ-033 Round-robin selection SHALL be a single combinational priority search; no per-requester FSMs.

Verification
REQ-034 Single op: reset, req_valid=0001, A=10, B=10, cin=0, rsp_ready=1 -> accept edge N, rsp_valid=0001 at N+2, rsp_sum=20, rsp_cout=0.
REQ-035 Overflow: A=16'hFFFF, B=16'h0001, cin=1 -> rsp_sum=16'h0001, rsp_cout=1.
REQ-036 Fairness: req_valid=1111 held, each A=i, B=100 -> grants in order 0,1,2,3,0; each rsp_sum=100+i to its owner only.
REQ-037 Backpressure: requester 2 result with rsp_ready[2]=0 for 5 cycles, rsp_ready[0]=1 -> rsp_valid=0100 held, sum stable, req_ready=0 throughout; completes the edge rsp_ready[2] rises.
REQ-038 Reset in ADD: accept op, assert Reset next cycle -> rsp_valid never rises, busy=0, next grant goes to requester 0.
